// File: rtl/bht_update_scheduler.sv
// bht_update_scheduler
// Merges branch-resolution updates from execute pipes A and B into a small
// in-order FIFO and drains one entry per cycle onto the single-port BHT
// update interface.
// Build option: BHT_SCHED_BYPASS_EN -- when defined and the FIFO is empty and
// not frozen, an accepted request is forwarded to the table in the same cycle
// instead of being written (A wins if both arrive; B is then written).
module bht_update_scheduler #(
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic             REQ_A_VALID,
  output logic             REQ_A_READY,
  input  logic [63:0]      REQ_A_PC,
  input  logic             REQ_A_TAKEN,
  input  logic             REQ_B_VALID,
  output logic             REQ_B_READY,
  input  logic [63:0]      REQ_B_PC,
  input  logic             REQ_B_TAKEN,
  input  logic             FREEZE,
  output logic             UPDATE_VALID,
  output logic [63:0]      UPDATE_PC,
  output logic             UPDATE_TAKEN,
  output logic [CNT_W-1:0] OCCUPANCY,
  output logic             IDLE
);

  localparam int               PW      = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic             PRIO_A  = 1'b0;
  localparam logic             PRIO_B  = 1'b1;

  // Entry layout: {TAKEN, PC[63:0]}
  logic [64:0]      mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [PW-1:0]    waddr1;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] free_w;
  logic [CNT_W-1:0] n_wr;
  logic             prio_q, prio_d;
  logic             acc_a, acc_b;
  logic             pop;
  logic             bypass;
  logic             we0, we1;
  logic [64:0]      wdata0, wdata1;

  // Ready/grant: space is judged on the registered count only, so a pop this
  // cycle never frees a slot for this cycle's requests.
  always_comb begin
    free_w      = DEPTH_C - count_q;
    REQ_A_READY = 1'b0;
    REQ_B_READY = 1'b0;
    prio_d      = prio_q;
    if (free_w >= CNT_W'(2)) begin
      REQ_A_READY = 1'b1;
      REQ_B_READY = 1'b1;
    end else if (free_w == CNT_W'(1)) begin
      REQ_A_READY = (prio_q == PRIO_A) || !REQ_B_VALID;
      REQ_B_READY = (prio_q == PRIO_B) || !REQ_A_VALID;
      if (REQ_A_VALID && REQ_B_VALID) prio_d = ~prio_q;
    end
    acc_a = REQ_A_VALID && REQ_A_READY;
    acc_b = REQ_B_VALID && REQ_B_READY;
    pop   = (count_q != '0) && !FREEZE;
  end

`ifdef BHT_SCHED_BYPASS_EN
  assign bypass = (count_q == '0) && !FREEZE && (acc_a || acc_b);
`else
  assign bypass = 1'b0;
`endif

  // Write steering: A takes wptr, B wptr+1; a bypassed request is not stored.
  always_comb begin
    we0    = 1'b0;
    we1    = 1'b0;
    wdata0 = {REQ_A_TAKEN, REQ_A_PC};
    wdata1 = {REQ_B_TAKEN, REQ_B_PC};
    n_wr   = '0;
    if (bypass) begin
      if (acc_a && acc_b) begin
        we0    = 1'b1;
        wdata0 = {REQ_B_TAKEN, REQ_B_PC};
        n_wr   = CNT_W'(1);
      end
    end else if (acc_a && acc_b) begin
      we0  = 1'b1;
      we1  = 1'b1;
      n_wr = CNT_W'(2);
    end else if (acc_a) begin
      we0  = 1'b1;
      n_wr = CNT_W'(1);
    end else if (acc_b) begin
      we0    = 1'b1;
      wdata0 = {REQ_B_TAKEN, REQ_B_PC};
      n_wr   = CNT_W'(1);
    end
    waddr1  = wptr_q + PW'(1);
    wptr_d  = wptr_q + PW'(n_wr);
    rptr_d  = pop ? rptr_q + PW'(1) : rptr_q;
    count_d = count_q + n_wr - CNT_W'(pop);
  end

  // Table-side outputs: head entry, or the live request when bypassing.
  always_comb begin
    UPDATE_VALID               = pop;
    {UPDATE_TAKEN, UPDATE_PC}  = mem_q[rptr_q];
    if (bypass) begin
      UPDATE_VALID              = 1'b1;
      {UPDATE_TAKEN, UPDATE_PC} = acc_a ? {REQ_A_TAKEN, REQ_A_PC}
                                        : {REQ_B_TAKEN, REQ_B_PC};
    end
    OCCUPANCY = count_q;
    IDLE      = (count_q == '0);
  end

  // Storage, pointers, occupancy and priority; reset discards all entries.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      prio_q  <= PRIO_A;
    end else begin
      if (we0) mem_q[wptr_q] <= wdata0;
      if (we1) mem_q[waddr1] <= wdata1;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      prio_q  <= prio_d;
    end
  end

endmodule

// File: tb/tb_bht_update_scheduler.sv
// Directed bench for bht_update_scheduler (default build, DEPTH=4).
module tb_bht_update_scheduler;

  logic        CLOCK, RESET_N;
  logic        REQ_A_VALID, REQ_A_READY, REQ_A_TAKEN;
  logic [63:0] REQ_A_PC;
  logic        REQ_B_VALID, REQ_B_READY, REQ_B_TAKEN;
  logic [63:0] REQ_B_PC;
  logic        FREEZE;
  logic        UPDATE_VALID, UPDATE_TAKEN;
  logic [63:0] UPDATE_PC;
  logic [2:0]  OCCUPANCY;
  logic        IDLE;

  int n_cmp = 0;
  int n_err = 0;
  logic [64:0] obs [$];

  bht_update_scheduler #(.DEPTH(4)) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N),
    .REQ_A_VALID(REQ_A_VALID), .REQ_A_READY(REQ_A_READY),
    .REQ_A_PC(REQ_A_PC), .REQ_A_TAKEN(REQ_A_TAKEN),
    .REQ_B_VALID(REQ_B_VALID), .REQ_B_READY(REQ_B_READY),
    .REQ_B_PC(REQ_B_PC), .REQ_B_TAKEN(REQ_B_TAKEN),
    .FREEZE(FREEZE),
    .UPDATE_VALID(UPDATE_VALID), .UPDATE_PC(UPDATE_PC),
    .UPDATE_TAKEN(UPDATE_TAKEN),
    .OCCUPANCY(OCCUPANCY), .IDLE(IDLE)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  // Record every update the table sees, sampled mid-cycle.
  always @(negedge CLOCK) if (RESET_N && UPDATE_VALID) obs.push_back({UPDATE_TAKEN, UPDATE_PC});

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLOCK);
    #2;
  endtask

  task automatic idle_inputs();
    REQ_A_VALID = 0; REQ_A_PC = '0; REQ_A_TAKEN = 0;
    REQ_B_VALID = 0; REQ_B_PC = '0; REQ_B_TAKEN = 0;
    FREEZE = 0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 20 && !IDLE; i++) tick();
    #1;
    n_cmp++; if (IDLE !== 1'b1) begin n_err++; $display("FAIL %s_drain: IDLE=%b want 1", name, IDLE); end
  endtask

  task automatic test_reset();
    RESET_N = 0;
    idle_inputs();
    repeat (2) @(posedge CLOCK);
    #2 RESET_N = 1;
    #1;
    n_cmp++; if (REQ_A_READY !== 1'b1) begin n_err++; $display("FAIL rst_ready_a: got %b want 1", REQ_A_READY); end
    n_cmp++; if (REQ_B_READY !== 1'b1) begin n_err++; $display("FAIL rst_ready_b: got %b want 1", REQ_B_READY); end
    n_cmp++; if (UPDATE_VALID !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", UPDATE_VALID); end
    n_cmp++; if (UPDATE_PC !== 64'h0) begin n_err++; $display("FAIL rst_pc: got %h want 0", UPDATE_PC); end
    n_cmp++; if (UPDATE_TAKEN !== 1'b0) begin n_err++; $display("FAIL rst_taken: got %b want 0", UPDATE_TAKEN); end
    n_cmp++; if (OCCUPANCY !== 3'd0) begin n_err++; $display("FAIL rst_occ: got %0d want 0", OCCUPANCY); end
    n_cmp++; if (IDLE !== 1'b1) begin n_err++; $display("FAIL rst_idle: got %b want 1", IDLE); end
  endtask

  task automatic test_single();
    REQ_A_VALID = 1; REQ_A_PC = 64'h1000; REQ_A_TAKEN = 1;
    tick();
    idle_inputs();
    #1;
    n_cmp++; if (UPDATE_VALID !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", UPDATE_VALID); end
    n_cmp++; if (UPDATE_PC !== 64'h1000) begin n_err++; $display("FAIL single_pc: got %h want 1000", UPDATE_PC); end
    n_cmp++; if (UPDATE_TAKEN !== 1'b1) begin n_err++; $display("FAIL single_taken: got %b want 1", UPDATE_TAKEN); end
    n_cmp++; if (OCCUPANCY !== 3'd1) begin n_err++; $display("FAIL single_occ: got %0d want 1", OCCUPANCY); end
    tick(); #1;
    n_cmp++; if (UPDATE_VALID !== 1'b0) begin n_err++; $display("FAIL single_after_valid: got %b want 0", UPDATE_VALID); end
    n_cmp++; if (IDLE !== 1'b1) begin n_err++; $display("FAIL single_after_idle: got %b want 1", IDLE); end
  endtask

  task automatic test_dual();
    REQ_A_VALID = 1; REQ_A_PC = 64'h2000; REQ_A_TAKEN = 1;
    REQ_B_VALID = 1; REQ_B_PC = 64'h2004; REQ_B_TAKEN = 0;
    #1;
    n_cmp++; if ({REQ_A_READY, REQ_B_READY} !== 2'b11) begin n_err++; $display("FAIL dual_ready: got %b want 11", {REQ_A_READY, REQ_B_READY}); end
    tick();
    idle_inputs();
    #1;
    n_cmp++; if (OCCUPANCY !== 3'd2) begin n_err++; $display("FAIL dual_occ: got %0d want 2", OCCUPANCY); end
    n_cmp++; if ({UPDATE_VALID, UPDATE_TAKEN, UPDATE_PC} !== {2'b11, 64'h2000}) begin n_err++; $display("FAIL dual_first: got v=%b t=%b pc=%h want v=1 t=1 pc=2000", UPDATE_VALID, UPDATE_TAKEN, UPDATE_PC); end
    tick(); #1;
    n_cmp++; if ({UPDATE_VALID, UPDATE_TAKEN, UPDATE_PC} !== {2'b10, 64'h2004}) begin n_err++; $display("FAIL dual_second: got v=%b t=%b pc=%h want v=1 t=0 pc=2004", UPDATE_VALID, UPDATE_TAKEN, UPDATE_PC); end
    tick(); #1;
    n_cmp++; if ({UPDATE_VALID, IDLE} !== 2'b01) begin n_err++; $display("FAIL dual_end: got v=%b idle=%b want v=0 idle=1", UPDATE_VALID, IDLE); end
  endtask

  task automatic test_contention();
    logic [63:0] exp_pc [6];
    logic        exp_a;
    exp_pc[0] = 64'h100; exp_pc[1] = 64'h104; exp_pc[2] = 64'h108;
    exp_pc[3] = 64'h200; exp_pc[4] = 64'h304; exp_pc[5] = 64'h208;
    obs.delete();
    FREEZE = 1;
    REQ_A_VALID = 1; REQ_A_PC = 64'h100; REQ_B_VALID = 1; REQ_B_PC = 64'h104;
    tick();
    REQ_B_VALID = 0; REQ_A_PC = 64'h108;
    tick(); #1;
    n_cmp++; if (OCCUPANCY !== 3'd3) begin n_err++; $display("FAIL cont_fill_occ: got %0d want 3", OCCUPANCY); end
    FREEZE = 0;
    for (int k = 0; k < 3; k++) begin
      REQ_A_VALID = 1; REQ_A_PC = 64'h200 + 64'(4 * k);
      REQ_B_VALID = 1; REQ_B_PC = 64'h300 + 64'(4 * k);
      exp_a = (k != 1);
      #1;
      n_cmp++; if ({REQ_A_READY, REQ_B_READY} !== {exp_a, !exp_a}) begin n_err++; $display("FAIL cont_grant%0d: got %b want %b", k, {REQ_A_READY, REQ_B_READY}, {exp_a, !exp_a}); end
      tick();
    end
    idle_inputs();
    wait_drain("cont");
    n_cmp++; if (obs.size() != 6) begin n_err++; $display("FAIL cont_count: got %0d want 6", obs.size()); end
    for (int i = 0; i < 6 && i < obs.size(); i++) begin
      n_cmp++; if (obs[i][63:0] !== exp_pc[i]) begin n_err++; $display("FAIL cont_order%0d: got %h want %h", i, obs[i][63:0], exp_pc[i]); end
    end
  endtask

  task automatic test_freeze_fill();
    logic [63:0] exp_pc [5];
    for (int i = 0; i < 5; i++) exp_pc[i] = 64'h400 + 64'(4 * i);
    obs.delete();
    FREEZE = 1;
    for (int k = 0; k < 4; k++) begin
      REQ_A_VALID = 1; REQ_A_PC = 64'h400 + 64'(8 * k);
      REQ_B_VALID = 1; REQ_B_PC = 64'h404 + 64'(8 * k);
      tick();
    end
    #1;
    n_cmp++; if (OCCUPANCY !== 3'd4) begin n_err++; $display("FAIL frz_occ: got %0d want 4", OCCUPANCY); end
    n_cmp++; if ({REQ_A_READY, REQ_B_READY} !== 2'b00) begin n_err++; $display("FAIL frz_ready: got %b want 00", {REQ_A_READY, REQ_B_READY}); end
    n_cmp++; if (UPDATE_VALID !== 1'b0) begin n_err++; $display("FAIL frz_valid: got %b want 0", UPDATE_VALID); end
    FREEZE = 0; REQ_B_VALID = 0; REQ_A_PC = 64'h410;
    #1;
    n_cmp++; if ({REQ_A_READY, UPDATE_VALID} !== 2'b01) begin n_err++; $display("FAIL frz_full_pop: got rdy=%b v=%b want rdy=0 v=1", REQ_A_READY, UPDATE_VALID); end
    tick(); #1;
    n_cmp++; if (REQ_A_READY !== 1'b1) begin n_err++; $display("FAIL frz_reready: got %b want 1", REQ_A_READY); end
    tick();
    idle_inputs();
    wait_drain("frz");
    n_cmp++; if (obs.size() != 5) begin n_err++; $display("FAIL frz_count: got %0d want 5", obs.size()); end
    for (int i = 0; i < 5 && i < obs.size(); i++) begin
      n_cmp++; if (obs[i][63:0] !== exp_pc[i]) begin n_err++; $display("FAIL frz_order%0d: got %h want %h", i, obs[i][63:0], exp_pc[i]); end
    end
  endtask

  task automatic test_wrap();
    int   sent = 0;
    int   guard = 0;
    logic acc;
    obs.delete();
    while (sent < 10 && guard < 200) begin
      FREEZE = 1'($urandom_range(0, 1));
      REQ_A_VALID = 1; REQ_A_PC = 64'(4 * sent); REQ_A_TAKEN = sent[0];
      #1;
      acc = REQ_A_READY;
      tick();
      if (acc) sent++;
      guard++;
    end
    n_cmp++; if (sent != 10) begin n_err++; $display("FAIL wrap_send: sent %0d want 10", sent); end
    idle_inputs();
    wait_drain("wrap");
    n_cmp++; if (obs.size() != 10) begin n_err++; $display("FAIL wrap_count: got %0d want 10", obs.size()); end
    for (int i = 0; i < 10 && i < obs.size(); i++) begin
      n_cmp++; if (obs[i] !== {i[0], 64'(4 * i)}) begin n_err++; $display("FAIL wrap_entry%0d: got t=%b pc=%h want t=%b pc=%h", i, obs[i][64], obs[i][63:0], i[0], 64'(4 * i)); end
    end
  endtask

  task automatic test_reset_mid();
    FREEZE = 1;
    REQ_A_VALID = 1; REQ_A_PC = 64'h500; REQ_B_VALID = 1; REQ_B_PC = 64'h504;
    tick();
    REQ_B_VALID = 0; REQ_A_PC = 64'h508;
    tick();
    idle_inputs();
    #1;
    n_cmp++; if ({UPDATE_VALID, OCCUPANCY} !== {1'b1, 3'd3}) begin n_err++; $display("FAIL mid_pre: got v=%b occ=%0d want v=1 occ=3", UPDATE_VALID, OCCUPANCY); end
    RESET_N = 0;
    #1;
    n_cmp++; if (OCCUPANCY !== 3'd0) begin n_err++; $display("FAIL mid_occ: got %0d want 0", OCCUPANCY); end
    n_cmp++; if (UPDATE_VALID !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %b want 0", UPDATE_VALID); end
    n_cmp++; if ({REQ_A_READY, REQ_B_READY} !== 2'b11) begin n_err++; $display("FAIL mid_ready: got %b want 11", {REQ_A_READY, REQ_B_READY}); end
    n_cmp++; if (UPDATE_PC !== 64'h0) begin n_err++; $display("FAIL mid_pc: got %h want 0", UPDATE_PC); end
    n_cmp++; if (IDLE !== 1'b1) begin n_err++; $display("FAIL mid_idle: got %b want 1", IDLE); end
    tick();
    RESET_N = 1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_dual();
    test_contention();
    test_freeze_fill();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bht_update_scheduler.md
# bht_update_scheduler

Arbitrates branch-resolution updates from two execute pipes (A, B) onto the single-port update interface of the branch history table. Accepted updates are buffered in a small in-order FIFO and drained one per cycle, so both pipes can resolve branches in the same cycle without losing training information. Sits between the branch units and the table's `UPDATE_VALID`/`UPDATE_PC`/`UPDATE_TAKEN` inputs.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `CNT_W`, `$clog2(DEPTH+1)` (localparam): occupancy width.

Ports:
- `CLOCK` in 1: clock, rising edge.
- `RESET_N` in 1: reset, asynchronous, active-low.
- `REQ_A_VALID` in 1: pipe A branch resolved.
- `REQ_A_READY` out 1: A accepted this cycle if `VALID && READY`.
- `REQ_A_PC` in 64: branch PC.
- `REQ_A_TAKEN` in 1: actual outcome.
- `REQ_B_VALID` / `REQ_B_READY` / `REQ_B_PC` / `REQ_B_TAKEN`: same for pipe B.
- `FREEZE` in 1: hold draining (debug/flush); requests still accepted while space remains.
- `UPDATE_VALID` out 1: update to table this cycle.
- `UPDATE_PC` out 64: PC of the update.
- `UPDATE_TAKEN` out 1: outcome of the update.
- `OCCUPANCY` out CNT_W: current FIFO count.
- `IDLE` out 1: `OCCUPANCY==0`.

## Operation
- Storage: DEPTH × {PC[63:0], TAKEN}; write pointer, read pointer (`$clog2(DEPTH)` bits, natural wrap), count register.
- `FREE = DEPTH - count`. A pop in the current cycle does not add space for this cycle's acceptance.
- Ready rules (valid never depends on ready):
  - `FREE ≥ 2`: both ready.
  - `FREE == 1`: `REQ_A_READY = PRIO==A || !REQ_B_VALID`; `REQ_B_READY = PRIO==B || !REQ_A_VALID`.
  - `FREE == 0`: neither ready.
- Priority register `PRIO`:
  - Resets to A.
  - On a `FREE==1` cycle with both valid, it flips to the non-granted pipe.
  - Otherwise it is unchanged.
- Write order: when both are accepted, A goes to `wptr` and B to `wptr+1`; `wptr` advances by the number accepted (0/1/2).
- Drain:
  - `UPDATE_VALID = (count != 0) && !FREEZE`.
  - `UPDATE_PC`/`UPDATE_TAKEN` = head entry, combinational from storage.
  - Pop (`rptr+1`) on every cycle `UPDATE_VALID` is high; the table always accepts.
- Count update: `count_next = count + accepted - pop`; never exceeds DEPTH and never underflows.
- Strict FIFO ordering: updates to the same index from older branches reach the table first.

## Timing
- Reset values:
  - `REQ_A_READY=1`, `REQ_B_READY=1` (FREE=DEPTH).
  - `UPDATE_VALID=0`, `UPDATE_PC=0`, `UPDATE_TAKEN=0`; storage clears to 0.
  - `OCCUPANCY=0`, `IDLE=1`, `PRIO=A`.
- Latency: a request accepted at edge N drives `UPDATE_VALID` in the cycle after edge N, unless it is behind older entries or `FREEZE` is high.
- Throughput: 1 update/cycle out, 2 requests/cycle in. Sustained dual issue fills the FIFO at +1/cycle.
- Full FIFO plus simultaneous pop: no acceptance that cycle. Ready reasserts the next cycle.
- `FREEZE` asserted: the head is held and pointers are stable. Release resumes draining the same cycle.
- Reset mid-operation: all entries are discarded and outputs return to reset values immediately (async).

## Configuration
- `BHT_SCHED_BYPASS_EN` defined:
  - Applies when `count==0` and `!FREEZE` and at least one request is accepted.
  - The accepted request (A if both) drives `UPDATE_*` combinationally in the same cycle and is not written.
  - If both are accepted, only B is written.
  - Zero-cycle latency when idle.
- Not defined: every update passes through the FIFO with ≥1 cycle latency.

## Test plan
- Reset: assert `RESET_N=0` mid-stream with 3 entries -> `OCCUPANCY=0`, `UPDATE_VALID=0`, both READY=1, `UPDATE_PC=0`.
- Single request: A, PC=0x1000, TAKEN=1 at edge N -> next cycle `UPDATE_VALID=1`, `UPDATE_PC=0x1000`, `UPDATE_TAKEN=1`; then idle.
  - With BYPASS_EN: same values in cycle N, `OCCUPANCY` stays 0.
- Dual request, empty FIFO, DEPTH=4: A=0x2000/T, B=0x2004/NT same cycle -> updates 0x2000 then 0x2004 on consecutive cycles.
- Contention at FREE=1, both valid for 3 consecutive single-slot cycles -> grants A, B, A; `PRIO` alternates.
- `FREEZE=1` with continuous dual requests -> `OCCUPANCY` reaches 4, both READY=0, `UPDATE_VALID=0`.
  - Release `FREEZE` -> 4 updates drain in acceptance order.
- Wrap-around: drive 10 sequential A requests (PC 0x0..0x24, step 4) with random `FREEZE` -> the output PC sequence matches the input exactly, with no drop or duplicate.
